// File: rtl/serial_pkg.sv
// Shared types and constants for the serial transmitter.
// Optional feature macro: SERIAL_TX_PARITY_EN (adds the even-parity state).
package serial_pkg;

    localparam int unsigned DATA_W    = 8;
    localparam int unsigned BIT_IDX_W = 3;

    localparam logic LINE_IDLE  = 1'b1;
    localparam logic LINE_START = 1'b0;
    localparam logic LINE_STOP  = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef SERIAL_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

endpackage

// File: rtl/bit_timer.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled and pulses
// bit_done in the last cycle of each bit period.
module bit_timer #(
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic Clk,
    input  logic Reset,
    input  logic en,
    output logic bit_done
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;

    assign bit_done = en && (cnt_q == CNT_MAX);

    // Held at zero while idle so every frame starts on a fresh bit period
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            cnt_q <= '0;
        end else if (!en || bit_done) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/serial_tx.sv
// Byte-wide serial transmitter: start bit, 8 data bits LSB first, stop bit.
// Define SERIAL_TX_PARITY_EN to insert an even-parity bit before stop.
module serial_tx
    import serial_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [DATA_W-1:0] Data,
    input  logic              Load,
    output logic              Ready,
    output logic              TxOut,
    output logic              Busy
);

    state_t                 state_q, state_d;
    logic [DATA_W-1:0]      shreg_q, shreg_d;
    logic [BIT_IDX_W-1:0]   idx_q, idx_d;
    logic                   tx_q, tx_d;
    logic                   ready_q, ready_d;
    logic                   busy_q, busy_d;
    logic                   bit_done;
`ifdef SERIAL_TX_PARITY_EN
    logic                   parity_q, parity_d;
`endif

    bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .Clk     (Clk),
        .Reset   (Reset),
        .en      (state_q != IDLE),
        .bit_done(bit_done)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q  <= IDLE;
            shreg_q  <= '0;
            idx_q    <= '0;
            tx_q     <= LINE_IDLE;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            idx_q    <= idx_d;
            tx_q     <= tx_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
`ifdef SERIAL_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    // Next state; outputs are derived from the next state so they register in step with it
    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        idx_d    = idx_q;
`ifdef SERIAL_TX_PARITY_EN
        parity_d = parity_q;
`endif

        case (state_q)
            IDLE: begin
                if (Load) begin
                    state_d  = START;
                    shreg_d  = Data;
`ifdef SERIAL_TX_PARITY_EN
                    parity_d = ^Data;
`endif
                end
            end
            START: begin
                if (bit_done) state_d = DATA;
            end
            DATA: begin
                if (bit_done) begin
                    if (idx_q == BIT_IDX_W'(DATA_W - 1)) begin
                        idx_d   = '0;
`ifdef SERIAL_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        idx_d   = idx_q + BIT_IDX_W'(1);
                        shreg_d = shreg_q >> 1;
                    end
                end
            end
`ifdef SERIAL_TX_PARITY_EN
            PARITY: begin
                if (bit_done) state_d = STOP;
            end
`endif
            STOP: begin
                if (bit_done) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        case (state_d)
            START:   tx_d = LINE_START;
            DATA:    tx_d = shreg_d[0];
`ifdef SERIAL_TX_PARITY_EN
            PARITY:  tx_d = parity_d;
`endif
            STOP:    tx_d = LINE_STOP;
            default: tx_d = LINE_IDLE;
        endcase

        ready_d = (state_d == IDLE);
        busy_d  = (state_d != IDLE);
    end

    assign TxOut = tx_q;
    assign Ready = ready_q;
    assign Busy  = busy_q;

endmodule

// File: tb/tb_serial_tx.sv
// Self-checking bench for serial_tx: table of bytes with expected line frames,
// scoreboard queue of per-cycle TxOut values, plus directed corner sequences.
module tb_serial_tx;

    localparam int unsigned CPB = 4;
`ifdef SERIAL_TX_PARITY_EN
    localparam int unsigned NBITS = 11;
`else
    localparam int unsigned NBITS = 10;
`endif
    localparam int unsigned FRAME_CYC = NBITS * CPB;

    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;   // bit 0 = start, bits 1..8 = data LSB first, bit 9 = stop
        logic       par;
    } vec_t;

    vec_t vecs[7];

    logic       Clk = 1'b0;
    logic       Reset;
    logic       Load;
    logic [7:0] Data;
    logic       Ready;
    logic       TxOut;
    logic       Busy;

    int checks = 0;
    int errors = 0;
    logic exp_q[$];

    serial_tx #(
        .CLKS_PER_BIT(CPB)
    ) dut (
        .Clk  (Clk),
        .Reset(Reset),
        .Data (Data),
        .Load (Load),
        .Ready(Ready),
        .TxOut(TxOut),
        .Busy (Busy)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_idle(input string name);
        chk({name, "_txout"}, TxOut, 1'b1);
        chk({name, "_ready"}, Ready, 1'b1);
        chk({name, "_busy"},  Busy,  1'b0);
    endtask

    task automatic push_frame(input int i);
        logic [NBITS-1:0] bits;
`ifdef SERIAL_TX_PARITY_EN
        bits = {vecs[i].frame[9], vecs[i].par, vecs[i].frame[8:0]};
`else
        bits = vecs[i].frame;
`endif
        for (int b = 0; b < int'(NBITS); b++)
            for (int c = 0; c < int'(CPB); c++)
                exp_q.push_back(bits[b]);
    endtask

    // Drive a load at the current falling edge; returns at the first START sample
    task automatic kick(input int i);
        push_frame(i);
        Data = vecs[i].data;
        Load = 1'b1;
        @(negedge Clk);
    endtask

    task automatic check_cycles(input int n, input bit drop_load, input int poke_at,
                                input logic poke_load, input logic [7:0] poke_data);
        logic e;
        for (int k = 0; k < n; k++) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard_empty: got no expected entry at cycle %0d (t=%0t)", k, $time);
            end else begin
                e = exp_q.pop_front();
                chk("frame_txout", TxOut, e);
                chk("frame_ready", Ready, 1'b0);
                chk("frame_busy",  Busy,  1'b1);
            end
            if (k == 0 && drop_load) Load = 1'b0;
            if (k == poke_at) begin
                Data = poke_data;
                Load = poke_load;
            end
            if (k == poke_at + 1 && drop_load) Load = 1'b0;
            @(negedge Clk);
        end
    endtask

    initial begin
        vecs[0] = '{8'hA5, 10'b1_10100101_0, 1'b0};
        vecs[1] = '{8'h07, 10'b1_00000111_0, 1'b1};
        vecs[2] = '{8'h00, 10'b1_00000000_0, 1'b0};
        vecs[3] = '{8'hFF, 10'b1_11111111_0, 1'b0};
        vecs[4] = '{8'h3C, 10'b1_00111100_0, 1'b0};
        vecs[5] = '{8'h5A, 10'b1_01011010_0, 1'b0};
        vecs[6] = '{8'h01, 10'b1_00000001_0, 1'b1};

        Reset = 1'b1;
        Load  = 1'b0;
        Data  = 8'h00;
        @(negedge Clk);
        @(negedge Clk);
        check_idle("reset");
        Reset = 1'b0;
        @(negedge Clk);
        check_idle("post_reset");

        // Table: every byte as a standalone frame with an idle gap after it
        for (int i = 0; i < 7; i++) begin
            kick(i);
            check_cycles(FRAME_CYC, 1'b1, -1, 1'b0, 8'h00);
            check_idle("frame_end");
            @(negedge Clk);
            check_idle("gap");
        end

        // Load pulsed mid-frame is ignored
        kick(0);
        check_cycles(FRAME_CYC, 1'b1, 12, 1'b1, 8'hFF);
        check_idle("ignore_end");
        @(negedge Clk);
        check_idle("ignore_gap");

        // Data changed after acceptance does not alter the frame
        kick(5);
        check_cycles(FRAME_CYC, 1'b1, 2, 1'b0, 8'hC3);
        check_idle("late_data_end");
        @(negedge Clk);

        // Back-to-back: Load held high, exactly one idle cycle between frames
        kick(2);
        check_cycles(FRAME_CYC, 1'b0, 5, 1'b1, 8'hFF);
        check_idle("b2b_gap");
        push_frame(3);
        @(negedge Clk);
        check_cycles(FRAME_CYC, 1'b1, -1, 1'b0, 8'h00);
        check_idle("b2b_end");
        @(negedge Clk);

        // Reset during data bit 3 aborts immediately
        kick(0);
        check_cycles(17, 1'b1, -1, 1'b0, 8'h00);
        Reset = 1'b1;
        #1;
        check_idle("async_reset");
        exp_q.delete();
        @(negedge Clk);
        check_idle("reset_hold");
        Reset = 1'b0;
        @(negedge Clk);
        check_idle("reset_release");
        @(negedge Clk);
        check_idle("reset_quiet");
        kick(4);
        check_cycles(FRAME_CYC, 1'b1, -1, 1'b0, 8'h00);
        check_idle("after_reset_end");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_tx.md
SERIAL_TX -- requirements
Module: serial_tx

Interface
REQ-001 Parameter: CLKS_PER_BIT, default 4, number of Clk cycles each serial bit is held on TxOut (legal range 2..255).
REQ-002 Port: Clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: Reset  input  1  asynchronous, active-high reset.
REQ-004 Port: Data  input  8  parallel byte to transmit; sampled only on an accepted load.
REQ-005 Port: Load  input  1  load request; accepted only in a cycle where Ready=1.
REQ-006 Port: Ready  output  1  high when idle and able to accept a byte.
REQ-007 Port: TxOut  output  1  serial line; idle level 1.
REQ-008 Port: Busy  output  1  high while a frame is being shifted out; always the inverse of Ready.

Function
REQ-009 The FSM states SHALL be IDLE, START, DATA, PARITY (present only with SERIAL_TX_PARITY_EN), and STOP.
REQ-010 In IDLE: TxOut=1, Ready=1. Load=1 at a rising edge latches Data into an 8-bit shift register and moves to START.
REQ-011 START SHALL drive TxOut=0 for exactly CLKS_PER_BIT cycles, then move to DATA.
REQ-012 DATA SHALL send the 8 bits LSB first, each for CLKS_PER_BIT cycles, under a 3-bit bit index running 0..7.
REQ-013 After bit 7, the FSM SHALL move to PARITY if enabled, otherwise to STOP.
REQ-014 STOP SHALL drive TxOut=1 for CLKS_PER_BIT cycles, then return to IDLE.
REQ-015 Ready SHALL fall in the first START cycle and rise in the first IDLE cycle after STOP.
REQ-016 Latency: TxOut SHALL go low exactly one cycle after the edge that accepts Load.
REQ-017 Load while Ready=0 SHALL be ignored, and changes to Data after acceptance SHALL NOT affect the frame in flight.
REQ-018 Back-to-back frames: Load held high SHALL start the next frame from the first IDLE cycle, giving exactly one idle cycle (TxOut=1) between frames.
REQ-019 The bit-timing counter SHALL count 0..CLKS_PER_BIT-1 and wrap to 0 on each bit boundary; the bit index SHALL wrap from 7 only on leaving DATA.
REQ-020 Frame length SHALL be 10*CLKS_PER_BIT cycles without parity and 11*CLKS_PER_BIT cycles with parity.

Reset
REQ-021 Reset=1 SHALL, without waiting for a clock edge, force state=IDLE, TxOut=1, Ready=1, Busy=0, counters=0, and shift register=0.
REQ-022 Reset asserted mid-frame SHALL abort the frame with no further data bits; after release, the first Load is handled as in REQ-010.

Configuration
REQ-023 With macro SERIAL_TX_PARITY_EN defined, the PARITY state SHALL send an even-parity bit (XOR of the 8 latched bits) for CLKS_PER_BIT cycles between DATA and STOP.
REQ-024 Without SERIAL_TX_PARITY_EN, the PARITY state and parity logic SHALL be absent and DATA SHALL go directly to STOP.

Structure
REQ-025 A shared package serial_pkg SHALL hold the FSM state typedef, the data-width constant (8), and the idle/start/stop line-level constants.
REQ-026 A sub-module bit_timer SHALL own the CLKS_PER_BIT counter and emit a one-cycle bit_done pulse; serial_tx instantiates it once.

Verification
REQ-027 Directed scenarios, all with CLKS_PER_BIT=4:
- Reset, then Data=8'hA5 with Load for 1 cycle -> TxOut = 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles; Ready low for 40 cycles.
- Parity build, Data=8'h07 -> parity bit 1 inserted before stop; frame 44 cycles; Data=8'hA5 -> parity bit 0.
- Load pulsed again at cycle 12 of a frame -> ignored; frame unchanged; Ready stays low until frame end.
- Load held high with Data=8'h00 then 8'hFF -> two frames separated by exactly 1 idle cycle of TxOut=1.
- Reset asserted during data bit 3 -> TxOut=1 and Ready=1 immediately; new frame 8'h3C after release is transmitted correctly.
- Data changed at cycle 2 after accept -> transmitted byte equals the value latched at acceptance.
